// File: rtl/gelato_fetch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gelato_fetch_scheduler
// Purpose  : Fetch-stage warp scheduler sitting behind the split table.
//            Picks one eligible warp (valid and not already in flight) per
//            issue in round-robin order and presents it as a registered
//            valid/ready request to the I-cache. Each warp may have at most
//            one fetch outstanding; decode releases it once the split table
//            holds the next PC.
// Ports    : clk, rst_n           - clock, async active-low reset
//            rdy                  - global enable, 0 freezes all state
//            warp_valid/pc/split_num - per-warp split-table entries (packed)
//            fetch_valid/ready    - I-cache request handshake
//            fetch_warp_id/pc/split_num - request payload
//            release_valid/warp_id - decode retires a warp's in-flight fetch
//            flush                - drop pending request, clear in-flight bits
//            inflight             - per-warp outstanding-fetch bitmap
//            err_release          - sticky: release of a non-in-flight warp
// Revision : 1.0 - initial release
// ============================================================================
module gelato_fetch_scheduler #(
    parameter int WARP_NUM        = 4,
    parameter int PC_WIDTH        = 32,
    parameter int SPLIT_NUM_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                rdy,
    input  logic [WARP_NUM-1:0]                 warp_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]        warp_pc,
    input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] warp_split_num,
    output logic                                fetch_valid,
    input  logic                                fetch_ready,
    output logic [$clog2(WARP_NUM)-1:0]         fetch_warp_id,
    output logic [PC_WIDTH-1:0]                 fetch_pc,
    output logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_num,
    input  logic                                release_valid,
    input  logic [$clog2(WARP_NUM)-1:0]         release_warp_id,
    input  logic                                flush,
    output logic [WARP_NUM-1:0]                 inflight,
    output logic                                err_release
);

    localparam int ID_W = $clog2(WARP_NUM);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t                       state_q,     state_d;
    logic [ID_W-1:0]              warp_id_q,   warp_id_d;
    logic [PC_WIDTH-1:0]          pc_q,        pc_d;
    logic [SPLIT_NUM_WIDTH-1:0]   split_num_q, split_num_d;
    logic [WARP_NUM-1:0]          inflight_q,  inflight_d;
    logic                         err_q,       err_d;
    logic [ID_W-1:0]              rr_q,        rr_d;

    logic [WARP_NUM-1:0]          eligible;
    logic                         grant_found;
    logic [ID_W-1:0]              grant_id;
    logic [ID_W-1:0]              cand;

    // Eligibility uses the registered in-flight bits, so a release can never
    // enable a grant in its own cycle.
    assign eligible = warp_valid & ~inflight_q;

    // Round-robin search: first eligible warp at rr_q, rr_q+1, ... The ID_W
    // wide addition wraps naturally because WARP_NUM is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < WARP_NUM; k++) begin
            cand = rr_q + ID_W'(k);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        warp_id_d   = warp_id_q;
        pc_d        = pc_q;
        split_num_d = split_num_q;
        inflight_d  = inflight_q;
        err_d       = err_q;
        rr_d        = rr_q;

        if (rdy) begin
            if (flush) begin
                // Flush wins over grant, accept and release; rr_q is kept.
                state_d    = ST_IDLE;
                inflight_d = '0;
            end else begin
                if (release_valid) begin
                    if (inflight_q[release_warp_id]) begin
                        inflight_d[release_warp_id] = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end

                // A new grant is taken from IDLE, or on the accept edge of the
                // current request to sustain one request per cycle. The granted
                // warp is never in flight, so it cannot collide with a release.
                if ((state_q == ST_IDLE) || fetch_ready) begin
                    if (grant_found) begin
                        state_d                = ST_REQ;
                        warp_id_d              = grant_id;
                        pc_d                   = warp_pc[grant_id*PC_WIDTH +: PC_WIDTH];
                        split_num_d            = warp_split_num[grant_id*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
                        inflight_d[grant_id]   = 1'b1;
                        rr_d                   = grant_id + ID_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            warp_id_q   <= '0;
            pc_q        <= '0;
            split_num_q <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
            rr_q        <= '0;
        end else begin
            state_q     <= state_d;
            warp_id_q   <= warp_id_d;
            pc_q        <= pc_d;
            split_num_q <= split_num_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
            rr_q        <= rr_d;
        end
    end

    assign fetch_valid     = (state_q == ST_REQ);
    assign fetch_warp_id   = warp_id_q;
    assign fetch_pc        = pc_q;
    assign fetch_split_num = split_num_q;
    assign inflight        = inflight_q;
    assign err_release     = err_q;

endmodule
`default_nettype wire
